// File: rtl/sram_responder.sv
// SRAM device model: decodes CE_N/WE_N/OE_N/UB_N/LB_N, stores 32-bit words and drives SRAM_DQ after READ_LATENCY cycles.
// Optional protocol checker enabled with `define SRAM_RESP_CHECK_EN (proto_err tied 0 otherwise).
module sram_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_OE_N,
  input  logic        SRAM_UB_N,
  input  logic        SRAM_LB_N,
  input  logic [16:0] SRAM_ADDR,
  inout  wire  [31:0] SRAM_DQ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic        proto_err,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a write is any edge with CE_N=0 & WE_N=0; a read request is CE_N=0 & WE_N=1 & OE_N=0
  // held each cycle; DQ carries data only while the request is held and the FSM is in DRIVE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  logic [31:0]          r_mem [2**ADDR_BITS];
  state_t               r_state;
  logic [3:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_addr;
  logic [31:0]          r_rd_data;
  logic [15:0]          r_rd_count;
  logic [15:0]          r_wr_count;

  logic                 w_wr;
  logic                 w_rd_req;
  logic                 w_drive;
  logic [ADDR_BITS-1:0] w_addr;
  logic                 w_addr_chg;
  logic                 w_unused;

  assign w_addr     = SRAM_ADDR[ADDR_BITS-1:0];
  assign w_wr       = !SRAM_CE_N && !SRAM_WE_N;
  assign w_rd_req   = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
  assign w_addr_chg = (w_addr != r_addr);
  assign w_unused   = ^SRAM_ADDR[16:ADDR_BITS];

  // Drive enable is combinational so the bus is released the same cycle the controller turns it around.
  assign w_drive = (r_state == S_DRIVE) && w_rd_req && !rst;

  assign SRAM_DQ[31:16] = (w_drive && !SRAM_UB_N) ? r_rd_data[31:16] : 16'bz;
  assign SRAM_DQ[15:0]  = (w_drive && !SRAM_LB_N) ? r_rd_data[15:0]  : 16'bz;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      if (!SRAM_UB_N) r_mem[w_addr][31:16] <= SRAM_DQ[31:16];
      if (!SRAM_LB_N) r_mem[w_addr][15:0]  <= SRAM_DQ[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_rd_data  <= 32'd0;
      r_rd_count <= 16'd0;
      r_wr_count <= 16'd0;
    end else if (w_wr) begin
      r_wr_count <= r_wr_count + 16'd1;
      r_state    <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rd_req) begin
            r_addr <= w_addr;
            r_cnt  <= LAT_M1;
            if (LAT_M1 == 4'd0) begin
              r_state    <= S_DRIVE;
              r_rd_data  <= r_mem[w_addr];
              r_rd_count <= r_rd_count + 16'd1;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!w_rd_req) begin
            r_state <= S_IDLE;
          end else if (w_addr_chg) begin
            r_addr <= w_addr;
            r_cnt  <= LAT_M1;
            if (LAT_M1 == 4'd0) begin
              r_state    <= S_DRIVE;
              r_rd_data  <= r_mem[w_addr];
              r_rd_count <= r_rd_count + 16'd1;
            end
          end else if (r_cnt <= 4'd1) begin
            r_cnt      <= 4'd0;
            r_state    <= S_DRIVE;
            r_rd_data  <= r_mem[r_addr];
            r_rd_count <= r_rd_count + 16'd1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DRIVE: begin
          if (!w_rd_req) begin
            r_state <= S_IDLE;
          end else if (w_addr_chg) begin
            r_addr <= w_addr;
            r_cnt  <= LAT_M1;
            if (LAT_M1 == 4'd0) begin
              r_rd_data  <= r_mem[w_addr];
              r_rd_count <= r_rd_count + 16'd1;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_count    = r_rd_count;
  assign wr_count    = r_wr_count;
  assign o_dbg_state = r_state;

`ifdef SRAM_RESP_CHECK_EN
  logic r_prev_drive;
  logic r_proto_err;

  // Sticky until reset: write+output-enable overlap, write right after we drove, or unknown address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_drive <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_prev_drive <= w_drive;
      if ((!SRAM_CE_N && !SRAM_WE_N && !SRAM_OE_N) ||
          (!SRAM_WE_N && r_prev_drive) ||
          (!SRAM_CE_N && $isunknown(SRAM_ADDR)))
        r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: vector table for writes/reads/latency/aliasing, plus hand sequences
// for write-during-DRIVE and reset-mid-read. Released bus reads as all ones through a pullup.
module tb_sram_responder;

  localparam logic [31:0] REL = 32'hFFFF_FFFF;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_WAIT  = 2'd1;
  localparam logic [1:0]  ST_DRIVE = 2'd2;
  // Control field order: {ce_n, we_n, oe_n, ub_n, lb_n}
  localparam logic [4:0] C_WR     = 5'b00100;
  localparam logic [4:0] C_WR_UBM = 5'b00110;
  localparam logic [4:0] C_RD     = 5'b01000;
  localparam logic [4:0] C_RD_UBM = 5'b01010;
  localparam logic [4:0] C_IDL    = 5'b11100;

  typedef struct {
    logic [4:0]  ctl;
    logic [16:0] addr;
    logic [31:0] wd;
    logic [1:0]  st;
    logic [31:0] dq;
    logic        chk;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_n = 1'b1, we_n = 1'b1, oe_n = 1'b1, ub_n = 1'b0, lb_n = 1'b0;
  logic [16:0] addr = '0;
  logic        tb_oe = 1'b0;
  logic [31:0] tb_dq = '0;
  wire  [31:0] dq;
  logic [15:0] rd_count, wr_count;
  logic        proto_err;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vq[$];

  assign dq = tb_oe ? tb_dq : 32'bz;
  pullup (dq);

  always #5 clk = ~clk;

  sram_responder #(.ADDR_BITS(8), .READ_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .SRAM_ADDR(addr), .SRAM_DQ(dq),
    .rd_count(rd_count), .wr_count(wr_count),
    .proto_err(proto_err), .o_dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] ctl, input logic [16:0] a, input logic [31:0] wd,
                     input logic [1:0] st, input logic [31:0] exp_dq, input logic c);
    vq.push_back('{ctl: ctl, addr: a, wd: wd, st: st, dq: exp_dq, chk: c});
  endtask

  task automatic drive(input logic [4:0] ctl, input logic [16:0] a, input logic [31:0] wd);
    {ce_n, we_n, oe_n, ub_n, lb_n} = ctl;
    addr  = a;
    tb_dq = wd;
    tb_oe = !ctl[3];
  endtask

  // One bus cycle: inputs set just after the rising edge, outputs checked on the falling edge.
  task automatic cyc(input string name, input logic [4:0] ctl, input logic [16:0] a, input logic [31:0] wd,
                     input logic [1:0] st, input logic [31:0] exp_dq, input logic c);
    drive(ctl, a, wd);
    @(negedge clk);
    chk({name, " state"}, {30'd0, dbg_state}, {30'd0, st});
    if (c) chk({name, " dq"}, dq, exp_dq);
    @(posedge clk);
    #1;
  endtask

  initial begin
    add(C_WR,     17'h005, 32'hDEADBEEF, ST_IDLE,  REL,          1'b0);
    add(C_RD,     17'h005, 32'h0,        ST_IDLE,  REL,          1'b1);
    add(C_RD,     17'h005, 32'h0,        ST_WAIT,  REL,          1'b1);
    add(C_RD,     17'h005, 32'h0,        ST_DRIVE, 32'hDEADBEEF, 1'b1);
    add(C_IDL,    17'h000, 32'h0,        ST_DRIVE, REL,          1'b1);
    add(C_IDL,    17'h000, 32'h0,        ST_IDLE,  REL,          1'b1);
    add(C_WR,     17'h010, 32'hFFFFFFFF, ST_IDLE,  REL,          1'b0);
    add(C_WR_UBM, 17'h010, 32'h12345678, ST_IDLE,  REL,          1'b0);
    add(C_RD,     17'h010, 32'h0,        ST_IDLE,  REL,          1'b1);
    add(C_RD,     17'h010, 32'h0,        ST_WAIT,  REL,          1'b1);
    add(C_RD,     17'h010, 32'h0,        ST_DRIVE, 32'hFFFF5678, 1'b1);
    add(C_WR,     17'h003, 32'h03030303, ST_DRIVE, REL,          1'b0);
    add(C_WR,     17'h004, 32'h04040404, ST_IDLE,  REL,          1'b0);
    add(C_RD,     17'h003, 32'h0,        ST_IDLE,  REL,          1'b1);
    add(C_RD,     17'h003, 32'h0,        ST_WAIT,  REL,          1'b1);
    add(C_RD,     17'h003, 32'h0,        ST_DRIVE, 32'h03030303, 1'b1);
    add(C_RD,     17'h004, 32'h0,        ST_DRIVE, 32'h03030303, 1'b1);
    add(C_RD,     17'h004, 32'h0,        ST_WAIT,  REL,          1'b1);
    add(C_RD,     17'h004, 32'h0,        ST_DRIVE, 32'h04040404, 1'b1);
    add(C_RD_UBM, 17'h004, 32'h0,        ST_DRIVE, 32'hFFFF0404, 1'b1);
    add(C_RD,     17'h104, 32'h0,        ST_DRIVE, 32'h04040404, 1'b1);
    add(C_IDL,    17'h000, 32'h0,        ST_DRIVE, REL,          1'b1);
    add(C_WR,     17'h105, 32'hA5A5A5A5, ST_IDLE,  REL,          1'b0);
    add(C_RD,     17'h005, 32'h0,        ST_IDLE,  REL,          1'b1);
    add(C_RD,     17'h005, 32'h0,        ST_WAIT,  REL,          1'b1);
    add(C_RD,     17'h005, 32'h0,        ST_DRIVE, 32'hA5A5A5A5, 1'b1);
    add(C_IDL,    17'h000, 32'h0,        ST_DRIVE, REL,          1'b1);
    add(C_IDL,    17'h000, 32'h0,        ST_IDLE,  REL,          1'b1);

    // Clock/reset
    drive(C_IDL, 17'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    chk("reset dq", dq, REL);
    chk("reset rd_count", {16'd0, rd_count}, 32'd0);
    chk("reset wr_count", {16'd0, wr_count}, 32'd0);
    chk("reset proto_err", {31'd0, proto_err}, 32'd0);
    @(posedge clk);
    #1;

    foreach (vq[i]) begin
      cyc($sformatf("vec%0d", i), vq[i].ctl, vq[i].addr, vq[i].wd, vq[i].st, vq[i].dq, vq[i].chk);
    end
    chk("table rd_count", {16'd0, rd_count}, 32'd5);
    chk("table wr_count", {16'd0, wr_count}, 32'd6);

    // Write lands while the read is being driven: write wins, FSM drops to IDLE.
    cyc("wdrv rd0", C_RD,  17'h004, 32'h0,        ST_IDLE,  REL,          1'b1);
    cyc("wdrv rd1", C_RD,  17'h004, 32'h0,        ST_WAIT,  REL,          1'b1);
    cyc("wdrv rd2", C_RD,  17'h004, 32'h0,        ST_DRIVE, 32'h04040404, 1'b1);
    cyc("wdrv wr",  C_WR,  17'h004, 32'h0BADF00D, ST_DRIVE, REL,          1'b0);
    cyc("wdrv idl", C_IDL, 17'h000, 32'h0,        ST_IDLE,  REL,          1'b1);
    chk("wdrv wr_count", {16'd0, wr_count}, 32'd7);
    chk("wdrv rd_count", {16'd0, rd_count}, 32'd6);
    chk("wdrv proto_err", {31'd0, proto_err}, 32'd0);
    cyc("wdrv chk0", C_RD,  17'h004, 32'h0, ST_IDLE,  REL,          1'b1);
    cyc("wdrv chk1", C_RD,  17'h004, 32'h0, ST_WAIT,  REL,          1'b1);
    cyc("wdrv chk2", C_RD,  17'h004, 32'h0, ST_DRIVE, 32'h0BADF00D, 1'b1);
    cyc("wdrv chk3", C_IDL, 17'h000, 32'h0, ST_DRIVE, REL,          1'b1);

    // Reset while waiting: counters clear, array keeps its contents.
    cyc("rst rd0", C_RD, 17'h005, 32'h0, ST_IDLE, REL, 1'b1);
    rst = 1'b1;
    cyc("rst rd1", C_RD, 17'h005, 32'h0, ST_WAIT, REL, 1'b1);
    rst = 1'b0;
    drive(C_RD, 17'h005, 32'h0);
    @(negedge clk);
    chk("rst after state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    chk("rst after dq", dq, REL);
    chk("rst after rd_count", {16'd0, rd_count}, 32'd0);
    chk("rst after wr_count", {16'd0, wr_count}, 32'd0);
    @(posedge clk);
    #1;
    cyc("rst rd3", C_RD,  17'h005, 32'h0, ST_WAIT,  REL,          1'b1);
    cyc("rst rd4", C_RD,  17'h005, 32'h0, ST_DRIVE, 32'hA5A5A5A5, 1'b1);
    cyc("rst idl", C_IDL, 17'h000, 32'h0, ST_DRIVE, REL,          1'b1);
    chk("rst final rd_count", {16'd0, rd_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
